// File: rtl/capsense_csd_scan_sequencer.sv
// rtl/capsense_csd_scan_sequencer.sv - CSD scan sequencer: sensor select, settle, measure, result handoff
module capsense_csd_scan_sequencer #(
    parameter int NumSensors    = 8,
    parameter int SettleCycles  = 16,
    parameter int PrechargeDiv  = 4,
    parameter int TimeoutCycles = 4096,
    parameter int CountWidth    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  scan_req,
    input  logic                  meas_done,
    input  logic [CountWidth-1:0] raw_count,
    input  logic                  res_ready,
    output logic                  start,
    output logic                  pulse,
    output logic [3:0]            sensor_sel,
    output logic                  sensor_en,
    output logic                  res_valid,
    output logic [CountWidth-1:0] res_data,
    output logic [3:0]            res_index,
    output logic                  res_timeout,
    output logic                  busy,
    output logic                  scan_done
);

    localparam int SW = (SettleCycles > 2) ? $clog2(SettleCycles) : 1;
    localparam int DW = (PrechargeDiv > 2) ? $clog2(PrechargeDiv) : 1;
    localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SettleCycles - 1);
    localparam logic [DW-1:0] DIV_MAX     = DW'(PrechargeDiv - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(TimeoutCycles - 1);
    localparam logic [3:0]    LAST_INDEX  = 4'(NumSensors - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_MEASURE,
        S_RELEASE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      index_q;
    logic [SW-1:0]   settle_q;
    logic [DW-1:0]   div_q;
    logic [TW-1:0]   tmo_q;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and Moore control outputs; enable low aborts from any busy state
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        sensor_en = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        scan_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (scan_req && enable) state_d = S_SELECT;
            end
            S_SELECT: begin
                sensor_en = 1'b1;
                state_d   = (settle_q == '0) ? S_MEASURE : S_SETTLE;
            end
            S_SETTLE: begin
                sensor_en = 1'b1;
                if (settle_q == '0) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                start     = 1'b1;
                sensor_en = 1'b1;
                if (meas_done || (tmo_q == TMO_MAX)) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                sensor_en = 1'b1;
                if (!meas_done) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = (index_q == LAST_INDEX) ? S_DONE : S_SELECT;
            end
            S_DONE: begin
                scan_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && !enable) state_d = S_IDLE;
    end

    // Sensor index and mux select; select holds its last value while idle
    always_ff @(posedge clock) begin
        if (!reset) begin
            index_q    <= '0;
            sensor_sel <= '0;
        end else if ((state_q == S_IDLE) && (state_d == S_SELECT)) begin
            index_q    <= '0;
            sensor_sel <= '0;
        end else if ((state_q == S_OUTPUT) && (state_d == S_SELECT)) begin
            index_q    <= index_q + 4'd1;
            sensor_sel <= index_q + 4'd1;
        end
    end

    // Settle counter: loaded on SELECT entry so SELECT itself is the first settle cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            settle_q <= '0;
        end else if ((state_d == S_SELECT) && (state_q != S_SELECT)) begin
            settle_q <= SETTLE_LOAD;
        end else if (((state_q == S_SELECT) || (state_q == S_SETTLE)) && (settle_q != '0)) begin
            settle_q <= settle_q - 1'b1;
        end
    end

    // Precharge divider and registered pulse; pulse only lands in cycles still inside MEASURE
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q <= '0;
            pulse <= 1'b0;
        end else begin
            if (state_q == S_MEASURE) begin
                div_q <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            end else begin
                div_q <= '0;
            end
            pulse <= (state_q == S_MEASURE) && (state_d == S_MEASURE) && (div_q == DIV_MAX);
        end
    end

    // Timeout counter: zero on MEASURE entry, saturates at its terminal value
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if (state_q != S_MEASURE) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Result capture on MEASURE exit; meas_done takes priority over timeout
    always_ff @(posedge clock) begin
        if (!reset) begin
            res_data    <= '0;
            res_index   <= '0;
            res_timeout <= 1'b0;
        end else if ((state_q == S_MEASURE) && (state_d == S_RELEASE)) begin
            res_index <= index_q;
            if (meas_done) begin
                res_data    <= raw_count;
                res_timeout <= 1'b0;
            end else begin
                res_data    <= '1;
                res_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capsense_csd_scan_sequencer.sv
// tb/tb_capsense_csd_scan_sequencer.sv - scoreboard bench for the CSD scan sequencer
module tb_capsense_csd_scan_sequencer;

    localparam int NS = 4;
    localparam int SC = 3;
    localparam int PD = 4;
    localparam int TC = 64;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          scan_req = 1'b0;
    logic          meas_done = 1'b0;
    logic [CW-1:0] raw_count = '0;
    logic          res_ready = 1'b0;
    logic          start, pulse, sensor_en, res_valid, res_timeout, busy, scan_done;
    logic [3:0]    sensor_sel, res_index;
    logic [CW-1:0] res_data;

    capsense_csd_scan_sequencer #(
        .NumSensors(NS), .SettleCycles(SC), .PrechargeDiv(PD),
        .TimeoutCycles(TC), .CountWidth(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .scan_req(scan_req),
        .meas_done(meas_done), .raw_count(raw_count), .res_ready(res_ready),
        .start(start), .pulse(pulse), .sensor_sel(sensor_sel), .sensor_en(sensor_en),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
        .res_timeout(res_timeout), .busy(busy), .scan_done(scan_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        to;
    } res_t;

    res_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus knobs shared by the main sequence and the channel model
    int dly_mode = 0;
    int dly_tab[4];
    int raw_mode = 0;
    int hold_mode = 0;
    int rdy_mode = 0;
    int stall_mode = 0;
    int stall_cnt = 0;
    int meas_num = 0;
    bit ignore_fall = 0;

    function automatic int pick_dly();
        case ($urandom_range(0, 6))
            0: return 0;
            1: return 1;
            2: return TC - 1;
            3: return TC;
            4: return 1000;
            default: return int'($urandom_range(2, 70));
        endcase
    endfunction

    // Measurement channel model: responds to start, predicts each result, checks timing
    int   cyc = 0;
    int   k = 0;
    int   dly = 0;
    int   exp_len = 0;
    int   en_rise = 0;
    int   hold_left = 0;
    logic start_prev = 1'b0;
    logic en_prev = 1'b0;
    always @(negedge clock) begin
        logic [15:0] v;
        cyc++;
        if (!meas_done) raw_count = 16'($urandom);
        if (sensor_en && !en_prev) en_rise = cyc;
        if (start && !start_prev) begin
            k = 0;
            check("settle_len", 32'(cyc - en_rise), SC);
            check("sel_at_start", 32'(sensor_sel), 32'(meas_num));
            if (dly_mode == 0) dly = 10;
            else if (dly_mode == 1) dly = dly_tab[meas_num % 4];
            else dly = pick_dly();
            exp_len = (dly < TC) ? dly + 1 : TC;
        end else if (start) begin
            k++;
        end
        if (start) begin
            check("pulse_meas", 32'(pulse), 32'((k > 0) && (k % PD == 0)));
            if (k == dly && dly < TC) begin
                v = raw_mode ? 16'($urandom) : 16'(16'h0100 + meas_num);
                raw_count = v;
                meas_done = 1'b1;
                hold_left = hold_mode ? int'($urandom_range(0, 2)) : 1;
                exp_q.push_back({v, 4'(meas_num), 1'b0});
                meas_num++;
            end else if (k == TC - 1 && dly >= TC) begin
                exp_q.push_back({16'hFFFF, 4'(meas_num), 1'b1});
                meas_num++;
            end
        end else begin
            check("pulse_idle", 32'(pulse), 0);
            if (start_prev && !ignore_fall) check("start_len", 32'(k + 1), 32'(exp_len));
            if (start_prev) ignore_fall = 0;
            if (meas_done) begin
                if (hold_left == 0) meas_done = 1'b0;
                else hold_left--;
            end
        end
        start_prev = start;
        en_prev = sensor_en;
    end

    // Result consumer: always ready, random, or a 20-cycle stall on sensor 1
    always @(posedge clock) begin
        #2;
        if (stall_mode != 0 && res_valid && res_index == 4'd1 && stall_cnt < 20) begin
            res_ready = 1'b0;
            stall_cnt++;
        end else if (rdy_mode != 0) begin
            res_ready = 1'($urandom_range(0, 1));
        end else begin
            res_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and scan end
    res_t held;
    bit   have_held = 0;
    int   done_cnt = 0;
    int   res_in_scan = 0;
    always @(negedge clock) begin
        res_t e;
        if (res_valid) begin
            check("en_in_output", 32'(sensor_en), 0);
            if (have_held) begin
                check("stall_data", 32'(res_data), 32'(held.data));
                check("stall_index", 32'(res_index), 32'(held.idx));
                check("stall_timeout", 32'(res_timeout), 32'(held.to));
            end
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got index %0d data %0h expected none", res_index, res_data);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_index", 32'(res_index), 32'(e.idx));
                    check("res_timeout", 32'(res_timeout), 32'(e.to));
                end
                res_in_scan++;
                have_held = 0;
            end else begin
                held = {res_data, res_index, res_timeout};
                have_held = 1;
            end
        end else begin
            have_held = 0;
        end
        if (scan_done) begin
            done_cnt++;
            check("results_per_scan", 32'(res_in_scan), NS);
            check("queue_empty_at_done", 32'(exp_q.size()), 0);
            res_in_scan = 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_scan();
        meas_num = 0;
        res_in_scan = 0;
        @(negedge clock);
        scan_req = 1'b1;
        @(negedge clock);
        scan_req = 1'b0;
    endtask

    task automatic wait_scan_done(input int budget);
        int n;
        n = 0;
        while (!scan_done && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("scan_done_seen", 32'(scan_done), 1);
        @(negedge clock);
        check("busy_after_done", 32'(busy), 0);
        check("scan_done_width", 32'(scan_done), 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({start, pulse, sensor_sel, sensor_en, res_valid, res_data,
                         res_index, res_timeout, busy, scan_done}), 0);
    endtask

    initial begin
        int d0;
        int n;
        cycles(3);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        enable = 1'b1;
        cycles(2);
        check("idle_busy", 32'(busy), 0);

        // Fixed 10-cycle response, data 0x0100+index, mid-scan request must be ignored
        d0 = done_cnt;
        start_scan();
        cycles(20);
        check("busy_mid_scan", 32'(busy), 1);
        scan_req = 1'b1;
        cycles(1);
        scan_req = 1'b0;
        wait_scan_done(3000);
        cycles(10);
        check("busy_after_ignored_req", 32'(busy), 0);
        check("done_count_single", 32'(done_cnt - d0), 1);

        // Timeout, done on last timeout cycle, done on entry, done one cycle too late
        dly_mode = 1;
        dly_tab = '{1000, TC - 1, 0, TC};
        raw_mode = 1;
        hold_mode = 1;
        rdy_mode = 1;
        start_scan();
        wait_scan_done(3000);

        // Back-pressure on sensor 1 result
        dly_mode = 2;
        rdy_mode = 0;
        stall_cnt = 0;
        stall_mode = 1;
        start_scan();
        wait_scan_done(3000);
        check("stall_cycles", 32'(stall_cnt), 20);
        stall_mode = 0;

        // Abort via enable during SETTLE of sensor 2, then restart
        rdy_mode = 1;
        start_scan();
        n = 0;
        while (!(sensor_en && !start && sensor_sel == 4'd2) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("reached_sensor2", 32'(sensor_sel), 2);
        @(negedge clock);
        check("in_settle_before_abort", 32'({sensor_en, start}), 32'(2'b10));
        enable = 1'b0;
        d0 = done_cnt;
        @(negedge clock);
        check("abort_busy", 32'(busy), 0);
        check("abort_sensor_en", 32'(sensor_en), 0);
        check("abort_start", 32'(start), 0);
        check("abort_scan_done", 32'(scan_done), 0);
        check("abort_queue", 32'(exp_q.size()), 0);
        cycles(5);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        enable = 1'b1;
        start_scan();
        wait_scan_done(3000);

        // Synchronous reset for one cycle in the middle of MEASURE
        dly_mode = 0;
        start_scan();
        n = 0;
        while (!start && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("reached_measure", 32'(start), 1);
        cycles(3);
        ignore_fall = 1;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("reset_mid_measure");
        reset = 1'b1;
        exp_q.delete();
        cycles(3);
        check("idle_after_reset", 32'(busy), 0);

        // Randomized scans
        dly_mode = 2;
        raw_mode = 1;
        hold_mode = 1;
        rdy_mode = 1;
        repeat (4) begin
            start_scan();
            wait_scan_done(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
